// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC register, ROM address drive and a small {pc, instr} FIFO to decode.
// Optional misaligned-redirect fault/halt is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_queue #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              DEPTH         = 2,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rd,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    output logic                     fetch_fault
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two and at least 2");
    end

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]          count_q, count_d;

    logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0]    instr_mem [DEPTH];

    logic                     push;
    logic                     pop;
    logic                     halted;
    logic [ADDRESS_WIDTH-1:0] redirect_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic misaligned;

    // Misaligned targets are taken verbatim; the sticky fault then stops all fetching.
    assign misaligned      = redirect && (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;

    always_comb begin
        fault_d = fault_q | misaligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign halted      = fault_q;
    assign fetch_fault = fault_q;
`else
    logic unused_redirect_low;

    assign unused_redirect_low = ^redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    assign halted              = 1'b0;
    assign fetch_fault         = 1'b0;
`endif

    assign imem_addr = pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = instr_mem[rd_ptr_q];
    assign out_pc    = pc_mem[rd_ptr_q];

    // Push ignores the same-cycle pop so the full check never depends on out_ready.
    assign push = !rst && !redirect && !halted && (count_q < CntW'(DEPTH));
    assign pop  = out_valid && out_ready && !redirect;

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (redirect) begin
            pc_d     = redirect_target;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + ADDRESS_WIDTH'(4);
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: out_valid masks whatever it holds.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= pc_q;
            instr_mem[wr_ptr_q] <= imem_rd;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table for the main flow plus a hand-written
// misaligned-redirect sequence whose expectations follow FETCH_ALIGN_CHECK_EN.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    int n_tests;
    int n_fail;

    fetch_queue #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .DEPTH        (2),
        .RESET_PC     (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom_word = 32'h0050_0093;
            32'h0000_0004: rom_word = 32'h00A0_0113;
            32'h0000_0008: rom_word = 32'h0020_81B3;
            default:       rom_word = a ^ 32'hDEAD_0000;
        endcase
    endfunction

    assign imem_rd = rom_word(imem_addr);

    typedef struct {
        logic        rst;
        logic        rdr;
        logic [31:0] rpc;
        logic        rdy;
        logic        chk;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
    } vec_t;

    localparam int NVec = 31;
    vec_t vecs [NVec];

    function automatic vec_t mk(input logic r, input logic d, input logic [31:0] p,
                                input logic y, input logic c, input logic v,
                                input logic [31:0] epc, input logic [31:0] ea);
        vec_t t;
        t.rst = r; t.rdr = d; t.rpc = p; t.rdy = y;
        t.chk = c; t.ev = v; t.epc = epc; t.eaddr = ea;
        return t;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic d, input logic [31:0] p, input logic y);
        rst = r; redirect = d; redirect_pc = p; out_ready = y;
    endtask

    // Compare at the falling edge, then advance past the next rising edge.
    task automatic check_step(input string name, input logic ev, input logic [31:0] epc,
                              input logic [31:0] eaddr, input logic efault);
        @(negedge clk);
        cmp({name, ".valid"}, {31'b0, out_valid}, {31'b0, ev});
        cmp({name, ".addr"}, imem_addr, eaddr);
        cmp({name, ".fault"}, {31'b0, fetch_fault}, {31'b0, efault});
        if (ev) begin
            cmp({name, ".pc"}, out_pc, epc);
            cmp({name, ".instr"}, out_instr, rom_word(epc));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //                rst rdr rpc           rdy chk ev  epc           eaddr
        // Reset then run
        vecs[0]  = mk(1, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0);
        vecs[1]  = mk(1, 0, 32'h0,         1, 1, 0, 32'h0,         32'h0);
        vecs[2]  = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,         32'h0);
        vecs[3]  = mk(0, 0, 32'h0,         1, 1, 1, 32'h0,         32'h4);
        vecs[4]  = mk(0, 0, 32'h0,         1, 1, 1, 32'h4,         32'h8);
        vecs[5]  = mk(0, 0, 32'h0,         1, 1, 1, 32'h8,         32'hC);
        // Backpressure
        vecs[6]  = mk(1, 0, 32'h0,         0, 1, 1, 32'hC,         32'h10);
        vecs[7]  = mk(0, 0, 32'h0,         0, 1, 0, 32'h0,         32'h0);
        vecs[8]  = mk(0, 0, 32'h0,         0, 1, 1, 32'h0,         32'h4);
        vecs[9]  = mk(0, 0, 32'h0,         0, 1, 1, 32'h0,         32'h8);
        vecs[10] = mk(0, 0, 32'h0,         0, 1, 1, 32'h0,         32'h8);
        vecs[11] = mk(0, 0, 32'h0,         0, 1, 1, 32'h0,         32'h8);
        vecs[12] = mk(0, 0, 32'h0,         1, 1, 1, 32'h0,         32'h8);
        vecs[13] = mk(0, 0, 32'h0,         1, 1, 1, 32'h4,         32'h8);
        vecs[14] = mk(0, 0, 32'h0,         1, 1, 1, 32'h8,         32'hC);
        // Redirect with queue holding 0x10/0x14
        vecs[15] = mk(0, 0, 32'h0,         1, 1, 1, 32'hC,         32'h10);
        vecs[16] = mk(0, 0, 32'h0,         0, 1, 1, 32'h10,        32'h14);
        vecs[17] = mk(0, 1, 32'h40,        1, 1, 1, 32'h10,        32'h18);
        vecs[18] = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,         32'h40);
        vecs[19] = mk(0, 0, 32'h0,         1, 1, 1, 32'h40,        32'h44);
        // PC wrap
        vecs[20] = mk(0, 1, 32'hFFFF_FFF8, 1, 1, 1, 32'h44,        32'h48);
        vecs[21] = mk(0, 0, 32'h0,         1, 1, 0, 32'h0,         32'hFFFF_FFF8);
        vecs[22] = mk(0, 0, 32'h0,         1, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
        vecs[23] = mk(0, 0, 32'h0,         1, 1, 1, 32'hFFFF_FFFC, 32'h0);
        vecs[24] = mk(0, 0, 32'h0,         1, 1, 1, 32'h0,         32'h4);
        // Reset mid-stream with count=2, pc=0x24
        vecs[25] = mk(0, 1, 32'h1C,        0, 1, 1, 32'h4,         32'h8);
        vecs[26] = mk(0, 0, 32'h0,         0, 1, 0, 32'h0,         32'h1C);
        vecs[27] = mk(0, 0, 32'h0,         0, 1, 1, 32'h1C,        32'h20);
        vecs[28] = mk(1, 0, 32'h0,         0, 1, 1, 32'h1C,        32'h24);
        vecs[29] = mk(0, 0, 32'h0,         0, 1, 0, 32'h0,         32'h0);
        vecs[30] = mk(0, 0, 32'h0,         1, 1, 1, 32'h0,         32'h4);

        drive(1, 0, 32'h0, 1);
        for (int i = 0; i < NVec; i++) begin
            drive(vecs[i].rst, vecs[i].rdr, vecs[i].rpc, vecs[i].rdy);
            @(negedge clk);
            if (vecs[i].chk) begin
                cmp($sformatf("v%0d.valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
                cmp($sformatf("v%0d.addr", i), imem_addr, vecs[i].eaddr);
                cmp($sformatf("v%0d.fault", i), {31'b0, fetch_fault}, 32'h0);
                if (vecs[i].ev) begin
                    cmp($sformatf("v%0d.pc", i), out_pc, vecs[i].epc);
                    cmp($sformatf("v%0d.instr", i), out_instr, rom_word(vecs[i].epc));
                end
            end
            @(posedge clk);
            #1;
        end

        // Misaligned redirect to 0x42 (queue holds head 0x4, pc 0x8)
        drive(0, 1, 32'h42, 1);
        check_step("mis_pre", 1, 32'h4, 32'h8, 0);
        drive(0, 0, 32'h0, 1);
`ifdef FETCH_ALIGN_CHECK_EN
        check_step("mis_next", 0, 32'h0, 32'h42, 1);
        check_step("mis_hold", 0, 32'h0, 32'h42, 1);
        drive(0, 1, 32'h80, 1);
        check_step("mis_aligned_rdr", 0, 32'h0, 32'h42, 1);
        drive(0, 0, 32'h0, 1);
        check_step("mis_still_fault", 0, 32'h0, 32'h80, 1);
        check_step("mis_still_halt", 0, 32'h0, 32'h80, 1);
        drive(1, 0, 32'h0, 1);
        check_step("mis_rst_edge", 0, 32'h0, 32'h80, 1);
        drive(0, 0, 32'h0, 1);
        check_step("mis_rst_clear", 0, 32'h0, 32'h0, 0);
        check_step("mis_restart", 1, 32'h0, 32'h4, 0);
`else
        check_step("mis_next", 0, 32'h0, 32'h40, 0);
        check_step("mis_run", 1, 32'h40, 32'h44, 0);
        check_step("mis_run2", 1, 32'h44, 32'h48, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end: owns the program counter and drives the byte address into the asynchronous instruction ROM.
- Captures each returned 32-bit instruction, paired with its PC, into a small FIFO. Decode drains the FIFO through a valid/ready handshake.
- Taken branches and jumps redirect the PC and flush stale entries.
- Sits between the ROM and the decode/register-file stage.

Parameters:
- ADDRESS_WIDTH, 32, width of the PC and ROM address.
- DATA_WIDTH, 32, instruction width.
- DEPTH, 2, FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- imem_addr  output  ADDRESS_WIDTH  byte address to ROM; equals current PC.
- imem_rd  input  DATA_WIDTH  instruction returned by ROM, same cycle (combinational).
- redirect  input  1  taken branch/jump this cycle.
- redirect_pc  input  ADDRESS_WIDTH  new PC when redirect=1.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode accepts head entry.
- out_instr  output  DATA_WIDTH  head instruction.
- out_pc  output  ADDRESS_WIDTH  PC of head instruction.
- fetch_fault  output  1  misaligned-redirect fault (optional feature only).

Behaviour:
- Reset is synchronous: when rst=1 at a clk edge, pc <= RESET_PC, count <= 0, rd/wr pointers <= 0, fetch_fault <= 0. Reset overrides redirect and all handshakes, including mid-operation. After reset, out_valid=0, and out_instr/out_pc are don't-care while invalid.
- imem_addr = pc combinationally, at all times.
- push = !rst && !redirect && !halted && (count < DEPTH). On push, the entry {pc, imem_rd} is written at wr_ptr and pc <= pc + 4.
- Push is gated on count < DEPTH only, not on the same-cycle pop. With DEPTH=2 and out_ready held high, sustained rate is one instruction per cycle.
- pop = out_valid && out_ready && !redirect. On pop, rd_ptr advances.
- out_valid = (count != 0). out_instr/out_pc are the head entry, read combinationally from storage.
- count update: count + push - pop. Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.
- PC arithmetic is modulo 2^ADDRESS_WIDTH: PC 0xFFFF_FFFC increments to 0x0000_0000.
- Latency:
  - The instruction at PC appears on out_instr the cycle after it is fetched.
  - The first out_valid is the cycle after rst deasserts.
- Redirect (highest priority after rst):
  - Queue is flushed: count <= 0, pointers <= 0.
  - pc <= redirect_pc.
  - No push and no pop that cycle; an out_ready handshake in that cycle is ignored and the entry is discarded.
  - The instruction at redirect_pc appears on out_instr 2 cycles after the redirect edge.
- Back-to-back redirects: each one overrides the previous; the last one wins.
- Full (count=DEPTH): PC holds, imem_addr is stable, no entry is lost.
- Empty with out_ready=1: out_valid=0, no pop.
- halted = 0 unless the optional feature is enabled.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Enabled:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_fault <= 1 (sticky) and sets halted.
  - The queue is flushed and pc <= redirect_pc unmodified.
  - While halted there are no pushes, so out_valid goes 0 once existing entries are popped.
  - Only rst clears fetch_fault and halted. A later aligned redirect does not clear them.
- Disabled:
  - pc <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}.
  - fetch_fault is tied to 0 and halted to 0.

Test Plan:
- Reset then run: rst=1 for 2 cycles, out_ready=1, ROM words 0x00500093, 0x00A00113, 0x002081B3 at 0/4/8. Required:
  - imem_addr = 0 during reset.
  - Cycle after deassert: out_valid=1, out_pc=0, out_instr=0x00500093.
  - Next two cycles: out_pc=4 (0x00A00113), then out_pc=8 (0x002081B3).
- Backpressure: out_ready=0 for 5 cycles after reset. Required:
  - count saturates at 2; imem_addr holds at 8.
  - Head stays out_pc=0.
  - On out_ready=1, entries 0, 4, 8 drain in order with no duplicates.
- Redirect with full queue: queue holds PC 0x10/0x14, redirect=1, redirect_pc=0x40, out_ready=1 that cycle. Required:
  - Next cycle: out_valid=0, imem_addr=0x40.
  - Following cycle: out_pc=0x40.
  - 0x10 and 0x14 are never accepted.
- PC wrap: redirect_pc=0xFFFFFFF8. Required: out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset mid-stream: assert rst while count=2 and pc=0x24. Required: next cycle count=0, out_valid=0, imem_addr=RESET_PC.
- Misaligned redirect: redirect_pc=0x42.
  - With FETCH_ALIGN_CHECK_EN: fetch_fault=1 next cycle, out_valid stays 0; a later aligned redirect does not clear it; rst does.
  - Without the macro: imem_addr=0x40 next cycle, fetch_fault=0.
